// File: rtl/game_engine.sv
`default_nettype none
// ============================================================================
// Module      : game_engine
// Description : Side-scrolling "flappy" game core. Keeps the bird (vertical
//               position/velocity), NUM_PIPES scrolling pipe obstacles, score
//               and best score. All motion advances on the one-clk frame
//               strobe 'tick'; start/flap/reset act on any clk.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1            system clock
//   rst       in   1            synchronous active-high reset
//   tick      in   1            frame strobe (one clk wide)
//   flap      in   1            debounced flap button (level)
//   start     in   1            start / restart request (level)
//   state     out  2            0 IDLE, 1 PLAY, 2 DYING, 3 OVER
//   score     out  16           current score (saturating)
//   hi_score  out  16           best score since reset
//   bird_y    out  10           bird top edge
//   bird_vel  out  8            bird velocity, two's complement, +down
//   pipe_x    out  NUM_PIPES*10 per-pipe right edge, pipe i at [10i+9:10i]
//   pipe_top  out  NUM_PIPES*10 per-pipe gap top
//   pipe_gap  out  NUM_PIPES*8  per-pipe gap height
// ============================================================================
module game_engine #(
  parameter int NUM_PIPES = 3,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PIPE_W    = 50,
  parameter int SPACING   = 240,
  parameter int BIRD_X    = 40,
  parameter int BIRD_SZ   = 16,
  parameter int SPEED     = 2,
  parameter int GRAVITY   = 1,
  parameter int FLAP_V    = 10,
  parameter int VMAX      = 8,
  parameter int GAP_MIN   = 100,
  parameter int TOP_MIN   = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      flap,
  input  logic                      start,
  output logic [1:0]                state,
  output logic [15:0]               score,
  output logic [15:0]               hi_score,
  output logic [9:0]                bird_y,
  output logic [7:0]                bird_vel,
  output logic [NUM_PIPES*10-1:0]   pipe_x,
  output logic [NUM_PIPES*10-1:0]   pipe_top,
  output logic [NUM_PIPES*8-1:0]    pipe_gap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
  localparam logic [9:0]  c_START_Y   = 10'(SCREEN_H / 2);
  localparam logic [9:0]  c_START_TOP = 10'((SCREEN_H - GAP_MIN) / 2);
  localparam logic [7:0]  c_START_GAP = 8'(GAP_MIN);
  localparam logic [9:0]  c_FLOOR_Y   = 10'(SCREEN_H - BIRD_SZ);
  // A respawned pipe lands one full ring of pipes behind, less this tick's step
  localparam logic [9:0]  c_WRAP      = 10'(NUM_PIPES * SPACING - SPEED);

  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_lfsr;
  logic                   r_flap_d;
  logic                   r_pending;
  logic [15:0]            r_score, r_hi;
  logic [9:0]             r_bird_y;
  logic [7:0]             r_vel;
  logic [9:0]             r_x   [NUM_PIPES];
  logic [9:0]             r_top [NUM_PIPES];
  logic [7:0]             r_gap [NUM_PIPES];
  logic [NUM_PIPES-1:0]   r_passed;

  logic                   w_start_game, w_play_tick, w_dying_tick, w_flap_rise;
  logic [15:0]            w_lfsr_nxt;
  logic [11:0]            w_bird_bot;
  logic                   w_floor_hit, w_hit;
  logic [NUM_PIPES-1:0]   w_pipe_hit, w_respawn, w_pass;
  logic [9:0]             w_x_mv [NUM_PIPES];
  logic [9:0]             w_new_top;
  logic [7:0]             w_new_gap;
  logic signed [9:0]      w_vel_grav;
  logic [7:0]             w_vel_nxt, w_vel_mag;
  logic                   w_y_under;
  logic [9:0]             w_y_nxt;
  logic [11:0]            w_y_fall;
  logic                   w_landed;
  logic [16:0]            w_score_sum;

  assign w_start_game = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && start;
  assign w_play_tick  = (r_state == ST_PLAY) && tick;
  assign w_dying_tick = (r_state == ST_DYING) && tick;
  assign w_flap_rise  = flap && !r_flap_d;

  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);

  // Respawn geometry: every pipe respawning this clk uses the same sample
  assign w_new_top = 10'(TOP_MIN) + {2'b00, r_lfsr[7:0]};
  assign w_new_gap = 8'(GAP_MIN) + {2'b00, r_lfsr[15:10]};

  // Collision uses the pre-update register values
  assign w_bird_bot  = {2'b00, r_bird_y} + 12'(BIRD_SZ);
  assign w_floor_hit = (w_bird_bot >= 12'(SCREEN_H));
  assign w_hit       = w_floor_hit || (|w_pipe_hit);

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    logic [11:0] w_x_ext;
    logic [11:0] w_gap_bot;
    assign w_x_ext   = {2'b00, r_x[i]};
    assign w_gap_bot = {2'b00, r_top[i]} + {4'b0000, r_gap[i]};
    // x - PIPE_W < BIRD_X + BIRD_SZ rearranged to avoid underflow near x = 0
    assign w_pipe_hit[i] = (w_x_ext > 12'(BIRD_X)) &&
                           (w_x_ext < 12'(BIRD_X + BIRD_SZ + PIPE_W)) &&
                           ((r_bird_y < r_top[i]) || (w_bird_bot > w_gap_bot));
    assign w_respawn[i]  = (r_x[i] <= 10'(SPEED));
    assign w_x_mv[i]     = w_respawn[i] ? (r_x[i] + c_WRAP) : (r_x[i] - 10'(SPEED));
    // Pass is judged on the post-move position, so score rises with x = BIRD_X
    assign w_pass[i]     = !r_passed[i] && !w_respawn[i] && (w_x_mv[i] <= 10'(BIRD_X));

    assign pipe_x  [10*i +: 10] = r_x[i];
    assign pipe_top[10*i +: 10] = r_top[i];
    assign pipe_gap[8*i  +: 8]  = r_gap[i];
  end

  assign w_score_sum = {1'b0, r_score} + 17'($countones(w_pass));

  // Bird: flap impulse overrides gravity; climbing clamps at the top edge
  assign w_vel_grav = $signed({{2{r_vel[7]}}, r_vel}) + $signed(10'(GRAVITY));
  assign w_vel_nxt  = r_pending ? 8'(-FLAP_V)
                    : ((w_vel_grav > $signed(10'(VMAX))) ? 8'(VMAX) : w_vel_grav[7:0]);
  assign w_vel_mag  = -w_vel_nxt;
  assign w_y_under  = w_vel_nxt[7] && ({2'b00, w_vel_mag} > r_bird_y);
  assign w_y_nxt    = w_y_under ? 10'd0 : (r_bird_y + {{2{w_vel_nxt[7]}}, w_vel_nxt});

  assign w_y_fall = {2'b00, r_bird_y} + 12'(VMAX);
  assign w_landed = ((w_y_fall + 12'(BIRD_SZ)) >= 12'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (start)                 w_state_nxt = ST_PLAY;
      ST_PLAY:          if (tick && w_hit)         w_state_nxt = ST_DYING;
      ST_DYING:         if (tick && w_landed)      w_state_nxt = ST_OVER;
      default:                                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= c_LFSR_SEED;
      r_flap_d  <= 1'b0;
      r_pending <= 1'b0;
      r_score   <= '0;
      r_hi      <= '0;
      r_bird_y  <= '0;
      r_vel     <= '0;
      r_passed  <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i]   <= '0;
        r_top[i] <= '0;
        r_gap[i] <= '0;
      end
    end else begin
      r_lfsr   <= w_lfsr_nxt;
      r_flap_d <= flap;
      if (w_start_game) begin
        // Start layout wins over any motion or flap edge in the same clk
        r_pending <= 1'b0;
        r_score   <= '0;
        r_bird_y  <= c_START_Y;
        r_vel     <= '0;
        r_passed  <= '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
          r_x[i]   <= 10'((i + 1) * SPACING + PIPE_W);
          r_top[i] <= c_START_TOP;
          r_gap[i] <= c_START_GAP;
        end
      end else begin
        // A fresh edge survives a consuming tick in the same clk
        if (w_flap_rise)      r_pending <= 1'b1;
        else if (w_play_tick) r_pending <= 1'b0;

        if (w_play_tick && !w_hit) begin
          r_vel    <= w_vel_nxt;
          r_bird_y <= w_y_nxt;
          r_score  <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
          for (int i = 0; i < NUM_PIPES; i++) begin
            r_x[i] <= w_x_mv[i];
            if (w_respawn[i]) begin
              r_top[i]    <= w_new_top;
              r_gap[i]    <= w_new_gap;
              r_passed[i] <= 1'b0;
            end else if (w_pass[i]) begin
              r_passed[i] <= 1'b1;
            end
          end
        end

        if (w_dying_tick) begin
          r_vel <= 8'(VMAX);
          if (w_landed) begin
            r_bird_y <= c_FLOOR_Y;
            if (r_score > r_hi) r_hi <= r_score;
          end else begin
            r_bird_y <= w_y_fall[9:0];
          end
        end
      end
    end
  end

  assign state    = r_state;
  assign score    = r_score;
  assign hi_score = r_hi;
  assign bird_y   = r_bird_y;
  assign bird_vel = r_vel;

endmodule
`default_nettype wire
